rv32i_run_ctrl: RTL and testbench

- Synthesisable run controller for the RV32I pipeline.
- Replaces fixed-delay reset and run windows with a counted reset sequence, a cycle-bounded run phase, halt detection, timeout and a pass/fail check of one watched register.
- Sits between the top-level clock/reset and the core; it drives the core reset and hold and observes write-back.
- Works in a testbench and on FPGA bring-up.

---
 rtl/rv32i_run_ctrl_pkg.sv | 19 +
 rtl/rv32i_run_ctrl_sat_counter.sv | 37 +++
 rtl/rv32i_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rv32i_run_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_run_ctrl_pkg.sv
// Shared types and constants for the RV32I run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_run_pkg;

  // Run-controller state encoding (3 bits, explicit values)
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } run_state_e;

  // Instruction encodings the upstream decode compares against to raise halt_req
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;

endpackage

// File: rtl/rv32i_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible one clock after clr/inc.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), clr, inc, cnt[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Run controller for an RV32I core: counted core reset, bounded run, halt/loop detect, pass check.
// Latency: all outputs registered; state and flags update on the clock edge after the cause.
// Backpressure: none; start is only honoured in IDLE/HALTED/TIMEOUT, ignored in RESET/RUN.
// Ports: clk, rst_n; start; wb_valid/wb_pc/halt_req (write-back observation);
//        chk_data/chk_expect (watched register); core_rst_n/core_hold (core control);
//        running/done/timeout/pass (status); cycle_cnt/instret_cnt (RUN statistics).
module rv32i_run_ctrl
  import rv32i_run_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 3,
  parameter int MAX_CYCLES = 24,
  parameter int LOOP_LIMIT = 4,
  parameter int AUTO_START = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 wb_valid,
  input  logic [D_WIDTH-1:0]   wb_pc,
  input  logic                 halt_req,
  input  logic [D_WIDTH-1:0]   chk_data,
  input  logic [D_WIDTH-1:0]   chk_expect,
  output logic                 core_rst_n,
  output logic                 core_hold,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LCW = $clog2(LOOP_LIMIT) + 1;

  run_state_e         state_q, state_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [D_WIDTH-1:0] last_pc_q, last_pc_d;
  logic               last_vld_q, last_vld_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               core_hold_q, core_hold_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               pass_q, pass_d;

  logic [LCW-1:0]     loop_cnt;
  logic               in_run;
  logic               retire;
  logic               pc_match;
  logic               loop_halt;
  logic               halt;
  logic               tmo_hit;
  logic               go_reset;

  assign in_run   = (state_q == RUN);
  assign retire   = in_run && wb_valid;
  // last_vld guards the first retirement of a run, so a first PC of 0 is not a false repeat
  assign pc_match = last_vld_q && (wb_pc == last_pc_q);
  // loop_cnt counts repeats beyond the first occurrence, so LOOP_LIMIT identical PCs
  // means this retire matches with LOOP_LIMIT-2 earlier repeats already counted
  assign loop_halt = retire && pc_match && (loop_cnt == LCW'(LOOP_LIMIT - 2));
  assign halt      = retire && (halt_req || loop_halt);
  assign tmo_hit   = in_run && !halt && (cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:            if (start || (AUTO_START != 0)) state_d = RESET;
      RESET:           if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = RUN;
      RUN: begin
        if (halt)         state_d = HALTED;
        else if (tmo_hit) state_d = TIMEOUT;
      end
      HALTED, TIMEOUT: if (start) state_d = RESET;
      default:         state_d = IDLE;
    endcase
  end

  // Counters and loop tracking are cleared on the edge that enters RESET
  assign go_reset = (state_q != RESET) && (state_d == RESET);

  always_comb begin
    rst_cnt_d  = (state_q == RESET) ? rst_cnt_q + RCW'(1) : '0;

    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    if (go_reset) begin
      last_pc_d  = '0;
      last_vld_d = 1'b0;
    end else if (retire) begin
      last_pc_d  = wb_pc;
      last_vld_d = 1'b1;
    end

    // Outputs are derived from the next state so they appear together with it
    core_rst_n_d = (state_d == RUN) || (state_d == HALTED) || (state_d == TIMEOUT);
    core_hold_d  = (state_d == HALTED) || (state_d == TIMEOUT);
    running_d    = (state_d == RUN);
    done_d       = (state_d == HALTED);
    timeout_d    = (state_d == TIMEOUT);

    // pass is sampled only on the halting edge and held afterwards
    if (in_run && (state_d == HALTED)) begin
      pass_d = (chk_data == chk_expect);
    end else if (state_d == HALTED) begin
      pass_d = pass_q;
    end else begin
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      last_pc_q    <= '0;
      last_vld_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_hold_q  <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      last_pc_q    <= last_pc_d;
      last_vld_q   <= last_vld_d;
      core_rst_n_q <= core_rst_n_d;
      core_hold_q  <= core_hold_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_reset),
    .inc   (in_run),
    .cnt   (cycle_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_reset),
    .inc   (retire),
    .cnt   (instret_cnt)
  );

  // A retirement with a new PC restarts the run of identical PCs
  sat_counter #(.W(LCW)) u_loop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_reset || (retire && !pc_match)),
    .inc   (retire && pc_match),
    .cnt   (loop_cnt)
  );

  assign core_rst_n = core_rst_n_q;
  assign core_hold  = core_hold_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Self-checking bench for rv32i_run_ctrl with a queue of expected end-of-run results.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32i_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        halt_req;
  logic [31:0] chk_data;
  logic [31:0] chk_expect;
  logic        core_rst_n;
  logic        core_hold;
  logic        running;
  logic        done;
  logic        timeout;
  logic        pass;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  rv32i_run_ctrl #(
    .D_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(3),
    .MAX_CYCLES(24), .LOOP_LIMIT(4), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .halt_req(halt_req),
    .chk_data(chk_data), .chk_expect(chk_expect),
    .core_rst_n(core_rst_n), .core_hold(core_hold), .running(running),
    .done(done), .timeout(timeout), .pass(pass),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        tmo;
    logic        pass;
    logic        hold;
    logic [31:0] instret;
    logic [31:0] cycles;
  } res_t;

  res_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mc = 0;   // model RUN cycle count
  int   mi = 0;   // model retire count

  function automatic string fmt(res_t r);
    return $sformatf("done=%b tmo=%b pass=%b hold=%b ret=%0d cyc=%0d",
                     r.done, r.tmo, r.pass, r.hold, r.instret, r.cycles);
  endfunction

  function automatic res_t observe();
    res_t r;
    r = {done, timeout, pass, core_hold, instret_cnt, cycle_cnt};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle of write-back stimulus; the model counts it as the DUT should
  task automatic step(input logic v, input logic [31:0] pc, input logic h);
    wb_valid = v;
    wb_pc    = pc;
    halt_req = h;
    tick();
    wb_valid = 1'b0;
    halt_req = 1'b0;
    mc++;
    if (v) mi++;
  endtask

  task automatic wait_running(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (running === 1'b1) ok = 1'b1;
    end
    mc = 0;
    mi = 0;
  endtask

  task automatic restart(output bit ok);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_running(ok);
  endtask

  task automatic wait_end(output bit ok);
    ok = (done === 1'b1) || (timeout === 1'b1);
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (done === 1'b1) || (timeout === 1'b1);
    end
  endtask

  task automatic test_reset();
    logic [37:0] o;
    rst_n = 1'b0; start = 1'b0; wb_valid = 1'b0; wb_pc = '0; halt_req = 1'b0;
    chk_data = '0; chk_expect = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = {core_rst_n, core_hold, running, done, timeout, pass, cycle_cnt};
      n_cmp++;
      if (o !== 38'd0 || instret_cnt !== 32'd0) begin
        n_err++;
        $display("FAIL reset_values: got rst_n_o=%b hold=%b run=%b done=%b tmo=%b pass=%b cyc=%0d ret=%0d, want all 0",
                 core_rst_n, core_hold, running, done, timeout, pass, cycle_cnt, instret_cnt);
      end
    end
  endtask

  task automatic test_autostart_timeout();
    int   n_run;
    res_t e;
    res_t o;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.push_back('{done: 1'b0, tmo: 1'b1, pass: 1'b0, hold: 1'b1, instret: 32'd0, cycles: 32'd24});
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (core_rst_n !== 1'b0) begin
        n_err++;
        $display("FAIL core_rst_low edge%0d: got %b want 0", i, core_rst_n);
      end
    end
    tick();
    n_cmp++;
    if (core_rst_n !== 1'b1 || running !== 1'b1 || cycle_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL run_entry: got core_rst_n=%b running=%b cyc=%0d want 1 1 0", core_rst_n, running, cycle_cnt);
    end
    n_run = 0;
    while (running === 1'b1 && n_run < 100) begin
      n_run++;
      tick();
    end
    n_cmp++;
    if (n_run != 24) begin
      n_err++;
      $display("FAIL run_length: got %0d cycles want 24", n_run);
    end
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL timeout_result: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_halt_req();
    bit   ok;
    res_t e;
    res_t o;
    restart(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t2_start: running=%b want 1 within 20 cycles", running); end
    chk_data = 32'h5; chk_expect = 32'h5;
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    while (mc < 9) step(1'b0, 32'h0, 1'b0);
    sbq.push_back('{done: 1'b1, tmo: 1'b0, pass: (chk_data == chk_expect), hold: 1'b1,
                    instret: 32'(mi + 1), cycles: 32'(mc + 1)});
    step(1'b1, 32'hC, 1'b1);
    wait_end(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t2_end: no done/timeout within 40 cycles"); end
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL t2_halt: got %s want %s", fmt(o), fmt(e)); end
    chk_data = 32'h9;
    tick(); tick();
    n_cmp++;
    if (pass !== 1'b1 || cycle_cnt !== 32'd10) begin
      n_err++;
      $display("FAIL t2_hold: got pass=%b cyc=%0d want pass=1 cyc=10", pass, cycle_cnt);
    end
  endtask

  task automatic test_loop_halt();
    bit          ok;
    res_t        e;
    res_t        o;
    logic [31:0] seq [6];
    seq[0] = 32'h10; seq[1] = 32'h10; seq[2] = 32'h14;
    seq[3] = 32'h10; seq[4] = 32'h10; seq[5] = 32'h10;
    chk_data = '0; chk_expect = '0;
    // Four 0x10 retires with an idle gap between the 2nd and 3rd
    restart(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t3a_start: running=%b want 1", running); end
    step(1'b1, 32'h10, 1'b0);
    step(1'b1, 32'h10, 1'b0);
    step(1'b0, 32'h10, 1'b0);
    step(1'b1, 32'h10, 1'b0);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL t3a_early: got done=%b after 3 repeats want 0", done); end
    sbq.push_back('{done: 1'b1, tmo: 1'b0, pass: 1'b1, hold: 1'b1, instret: 32'(mi + 1), cycles: 32'(mc + 1)});
    step(1'b1, 32'h10, 1'b0);
    wait_end(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t3a_end: no done/timeout within 40 cycles"); end
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL t3a_loop: got %s want %s", fmt(o), fmt(e)); end
    // A different PC in between restarts the repeat run
    restart(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t3b_start: running=%b want 1", running); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_cmp++;
      if (done !== 1'b0 || running !== 1'b1) begin
        n_err++;
        $display("FAIL t3b_nohalt[%0d]: got done=%b running=%b want 0 1", i, done, running);
      end
    end
    sbq.push_back('{done: 1'b1, tmo: 1'b0, pass: 1'b1, hold: 1'b1, instret: 32'(mi + 1), cycles: 32'(mc + 1)});
    step(1'b1, 32'h10, 1'b0);
    wait_end(ok);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (!ok || o !== e) begin n_err++; $display("FAIL t3b_loop: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_pass_fail();
    bit   ok;
    res_t e;
    res_t o;
    restart(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t4_start: running=%b want 1", running); end
    chk_data = 32'h7; chk_expect = 32'h5;
    step(1'b1, 32'h0, 1'b0);
    sbq.push_back('{done: 1'b1, tmo: 1'b0, pass: (chk_data == chk_expect), hold: 1'b1,
                    instret: 32'(mi + 1), cycles: 32'(mc + 1)});
    step(1'b1, 32'h20, 1'b1);
    wait_end(ok);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (!ok || o !== e) begin n_err++; $display("FAIL t4_fail_halt: got %s want %s", fmt(o), fmt(e)); end
    chk_data = 32'h5;
    tick(); tick(); tick();
    n_cmp++;
    if (pass !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL t4_pass_held: got pass=%b done=%b want 0 1", pass, done);
    end
  endtask

  task automatic test_halt_vs_timeout_restart();
    bit   ok;
    res_t e;
    res_t o;
    restart(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t5_start: running=%b want 1", running); end
    chk_data = 32'h1; chk_expect = 32'h1;
    while (mc < 23) step(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (cycle_cnt !== 32'(mc)) begin n_err++; $display("FAIL t5_pre: got cyc=%0d want %0d", cycle_cnt, mc); end
    sbq.push_back('{done: 1'b1, tmo: 1'b0, pass: 1'b1, hold: 1'b1, instret: 32'(mi + 1), cycles: 32'(mc + 1)});
    step(1'b1, 32'h30, 1'b1);
    wait_end(ok);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (!ok || o !== e) begin n_err++; $display("FAIL t5_halt_wins: got %s want %s", fmt(o), fmt(e)); end
    // start from HALTED clears everything on the same edge
    start = 1'b1; tick(); start = 1'b0;
    o = observe();
    n_cmp++;
    if (o !== res_t'(0) || core_rst_n !== 1'b0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL t5_restart_clear: got %s core_rst_n=%b running=%b want all 0", fmt(o), core_rst_n, running);
    end
    // start inside RESET must not stretch the 3-clock reset
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (running !== 1'b0 || core_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL t5_in_reset: got running=%b core_rst_n=%b want 0 0", running, core_rst_n);
    end
    tick(); tick();
    n_cmp++;
    if (running !== 1'b1 || cycle_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL t5_reset_len: got running=%b cyc=%0d want 1 0", running, cycle_cnt);
    end
    mc = 0; mi = 0;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    start = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    start = 1'b0;
    n_cmp++;
    if (running !== 1'b1 || cycle_cnt !== 32'(mc)) begin
      n_err++;
      $display("FAIL t5_start_in_run: got running=%b cyc=%0d want 1 %0d", running, cycle_cnt, mc);
    end
    sbq.push_back('{done: 1'b0, tmo: 1'b1, pass: 1'b0, hold: 1'b1, instret: 32'd0, cycles: 32'd24});
    wait_end(ok);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (!ok || o !== e) begin n_err++; $display("FAIL t5_timeout: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_async_reset();
    bit ok;
    restart(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t6_start: running=%b want 1", running); end
    step(1'b1, 32'h40, 1'b0);
    step(1'b1, 32'h44, 1'b0);
    while (mc < 7) step(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (cycle_cnt !== 32'd7 || instret_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL t6_pre: got cyc=%0d ret=%0d want 7 2", cycle_cnt, instret_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (core_rst_n !== 1'b0 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL t6_async: got core_rst_n=%b cyc=%0d ret=%0d running=%b want 0 0 0 0",
               core_rst_n, cycle_cnt, instret_cnt, running);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    wait_running(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t6_autostart: running=%b want 1 after release", running); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_autostart_timeout();
    test_halt_req();
    test_loop_halt();
    test_pass_fail();
    test_halt_vs_timeout_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
